// File: rtl/lcd_init_module_if.sv
// SPI writer handshake between the LCD init stage (master) and the shared SPI write module (slave).
interface lcd_init_module_if;
  logic       SPI_Start_Sig;
  logic [9:0] SPI_Data;
  logic       SPI_Done_Sig;

  modport master (output SPI_Start_Sig, output SPI_Data, input SPI_Done_Sig);
  modport slave  (input SPI_Start_Sig, input SPI_Data, output SPI_Done_Sig);
endinterface

// File: rtl/lcd_init_module.sv
// ST7565 power-up sequencer: panel hardware reset timing, then a fixed command list streamed to the SPI writer.
// Define LCD_INIT_CLEAR_EN to append a full display-RAM clear (8 pages x 128 columns) after the command list.
module lcd_init_module #(
  parameter int unsigned RST_LOW_CYC  = 50000,
  parameter int unsigned RST_WAIT_CYC = 250000,
  parameter logic [7:0]  CONTRAST     = 8'h20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_Sig,
  lcd_init_module_if.master spi,
  output logic              LCD_RST_Out,
  output logic              Done_Sig
);
  localparam int unsigned CNT_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) > 18) ? $clog2(CNT_MAX + 1) : 18;
  localparam int unsigned IDX_W   = 11;
  localparam int unsigned N_CMDS  = 9;
`ifdef LCD_INIT_CLEAR_EN
  localparam int unsigned N_WORDS = 1057;
`else
  localparam int unsigned N_WORDS = 9;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LOW, S_RST_WAIT, S_ISSUE, S_WAIT_DONE, S_GAP, S_DONE, S_HOLD
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_spi_start;
  logic [9:0]       r_spi_data;
  logic             r_lcd_rst;
  logic             r_done;
  logic [9:0]       w_word;
  logic             w_last;
`ifdef LCD_INIT_CLEAR_EN
  logic [2:0]       r_page;
  logic [7:0]       r_col;
`endif

  assign spi.SPI_Start_Sig = r_spi_start;
  assign spi.SPI_Data      = r_spi_data;
  assign LCD_RST_Out       = r_lcd_rst;
  assign Done_Sig          = r_done;
  assign w_last            = (r_idx == IDX_W'(N_WORDS - 1));

  always_comb begin
    w_word = '0;
    if (r_idx < IDX_W'(N_CMDS)) begin
      case (r_idx[3:0])
        4'd0:    w_word = 10'h0E2;
        4'd1:    w_word = 10'h0A2;
        4'd2:    w_word = 10'h0A0;
        4'd3:    w_word = 10'h0C8;
        4'd4:    w_word = 10'h02F;
        4'd5:    w_word = 10'h024;
        4'd6:    w_word = 10'h081;
        4'd7:    w_word = {2'b00, CONTRAST};
        4'd8:    w_word = 10'h0AF;
        default: w_word = '0;
      endcase
    end
`ifdef LCD_INIT_CLEAR_EN
    else begin
      // Each page is a 3-word address header followed by 128 zero data bytes.
      case (r_col)
        8'd0:    w_word = {2'b00, 4'hB, 1'b0, r_page};
        8'd1:    w_word = 10'h010;
        8'd2:    w_word = 10'h000;
        default: w_word = 10'h100;
      endcase
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_spi_start <= 1'b0;
      r_spi_data  <= '0;
      r_lcd_rst   <= 1'b1;
      r_done      <= 1'b0;
`ifdef LCD_INIT_CLEAR_EN
      r_page      <= '0;
      r_col       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start_Sig) begin
            r_state   <= S_RST_LOW;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_lcd_rst <= 1'b0;
`ifdef LCD_INIT_CLEAR_EN
            r_page    <= '0;
            r_col     <= '0;
`endif
          end
        end
        S_RST_LOW: begin
          if (r_cnt == CNT_W'(RST_LOW_CYC - 1)) begin
            r_cnt     <= '0;
            r_lcd_rst <= 1'b1;
            r_state   <= S_RST_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // SPI_Start_Sig/SPI_Data are loaded on the edge entering ISSUE so the
        // request is already visible while in ISSUE (keeps the one-cycle GAP).
        S_RST_WAIT: begin
          if (r_cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
            r_cnt       <= '0;
            r_spi_start <= 1'b1;
            r_spi_data  <= w_word;
            r_state     <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (spi.SPI_Done_Sig) begin
            r_spi_start <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_GAP;
`ifdef LCD_INIT_CLEAR_EN
              if (r_idx >= IDX_W'(N_CMDS)) begin
                if (r_col == 8'd130) begin
                  r_col  <= '0;
                  r_page <= r_page + 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end
`endif
            end
          end
        end
        S_GAP: begin
          r_spi_start <= 1'b1;
          r_spi_data  <= w_word;
          r_state     <= S_ISSUE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!Start_Sig) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_init_module.sv
// Self-checking bench for lcd_init_module: randomised SPI writer latency against a word-list reference model.
module tb_lcd_init_module;
  localparam int unsigned L        = 4;
  localparam int unsigned W        = 6;
  localparam logic [7:0]  CONTRAST = 8'h20;
  localparam int          BOUND    = 20000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic Start_Sig = 1'b0;
  logic LCD_RST_Out;
  logic Done_Sig;

  lcd_init_module_if spi();

  lcd_init_module #(.RST_LOW_CYC(L), .RST_WAIT_CYC(W), .CONTRAST(CONTRAST)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start_Sig  (Start_Sig),
    .spi        (spi),
    .LCD_RST_Out(LCD_RST_Out),
    .Done_Sig   (Done_Sig)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [9:0] exp_q[$];
  logic [9:0] cap_q[$];
  int cap_cyc[$];
  int done_cyc[$];
  int dsig_cyc[$];
  int hold_viol = 0;

  bit wr_en = 1'b1;
  bit wr_flush = 1'b0;
  int wr_lat = 3;
  bit wr_busy = 1'b0;
  bit wr_wait_low = 1'b0;
  bit wr_done = 1'b0;
  bit stray_done = 1'b0;
  int wr_cnt = 0;

  assign spi.SPI_Done_Sig = wr_done | stray_done;

  function automatic void build_expected();
    logic [7:0] cmds[9];
    cmds = '{8'hE2, 8'hA2, 8'hA0, 8'hC8, 8'h2F, 8'h24, 8'h81, CONTRAST, 8'hAF};
    exp_q.delete();
    foreach (cmds[i]) exp_q.push_back({2'b00, cmds[i]});
`ifdef LCD_INIT_CLEAR_EN
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back(10'h0B0 + 10'(p));
      exp_q.push_back(10'h010);
      exp_q.push_back(10'h000);
      for (int c = 0; c < 128; c++) exp_q.push_back(10'h100);
    end
`endif
  endfunction

  // SPI writer model: accepts a word on Start, answers Done after a latency, re-arms once Start drops.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      wr_done = 1'b0;
      if (Done_Sig === 1'b1) dsig_cyc.push_back(cyc);
      if (wr_busy && cap_q.size() > 0 &&
          (spi.SPI_Start_Sig !== 1'b1 || spi.SPI_Data !== cap_q[$])) hold_viol++;
      if (wr_flush) begin
        wr_busy = 1'b0;
        wr_wait_low = 1'b0;
      end else if (wr_busy) begin
        if (wr_cnt <= 1) begin
          wr_done = 1'b1;
          done_cyc.push_back(cyc);
          wr_busy = 1'b0;
          wr_wait_low = 1'b1;
        end else begin
          wr_cnt--;
        end
      end else if (wr_wait_low) begin
        if (spi.SPI_Start_Sig !== 1'b1) wr_wait_low = 1'b0;
      end else if (wr_en && spi.SPI_Start_Sig === 1'b1) begin
        cap_q.push_back(spi.SPI_Data);
        cap_cyc.push_back(cyc);
        wr_busy = 1'b1;
        wr_cnt = (wr_lat > 0) ? wr_lat : int'($urandom_range(1, 6));
      end
    end
  end

  task automatic clear_logs();
    cap_q.delete();
    cap_cyc.delete();
    done_cyc.delete();
    dsig_cyc.delete();
    hold_viol = 0;
  endtask

  task automatic wait_for_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge CLK);
      if (Done_Sig === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    Start_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (spi.SPI_Start_Sig !== 1'b0) begin errors++; $display("FAIL reset_spi_start got %b want 0", spi.SPI_Start_Sig); end
    checks++; if (spi.SPI_Data !== 10'h000) begin errors++; $display("FAIL reset_spi_data got %h want 000", spi.SPI_Data); end
    checks++; if (LCD_RST_Out !== 1'b1) begin errors++; $display("FAIL reset_lcd_rst got %b want 1", LCD_RST_Out); end
    checks++; if (Done_Sig !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done_Sig); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_command_stream();
    int ns;
    int lo_first = -1;
    int hi_first = -1;
    int st_first = -1;
    bit ok = 1'b0;
    clear_logs();
    wr_lat = 3;
    Start_Sig = 1'b1;
    ns = cyc + 1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge CLK);
      if (LCD_RST_Out === 1'b0 && lo_first < 0) lo_first = cyc;
      if (LCD_RST_Out === 1'b1 && lo_first >= 0 && hi_first < 0) hi_first = cyc;
      if (spi.SPI_Start_Sig === 1'b1 && st_first < 0) st_first = cyc;
      if (Done_Sig === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge CLK);
    checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got no Done_Sig want pulse within %0d cycles", BOUND); end
    checks++; if (lo_first != ns) begin errors++; $display("FAIL stream_rst_fall got cycle %0d want %0d", lo_first, ns); end
    checks++; if (hi_first != ns + int'(L)) begin errors++; $display("FAIL stream_rst_rise got cycle %0d want %0d", hi_first, ns + int'(L)); end
    checks++; if (st_first != ns + int'(L + W)) begin errors++; $display("FAIL stream_first_start got cycle %0d want %0d", st_first, ns + int'(L + W)); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (k >= cap_q.size()) begin errors++; $display("FAIL stream_word%0d got none want %h", k, exp_q[k]); break; end
      else if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL stream_word%0d got %h want %h", k, cap_q[k], exp_q[k]); end
    end
    for (int k = 1; k < cap_cyc.size() && k - 1 < done_cyc.size(); k++) begin
      checks++;
      if (cap_cyc[k] - done_cyc[k-1] != 2) begin errors++; $display("FAIL stream_gap%0d got %0d cycles want 2", k, cap_cyc[k] - done_cyc[k-1]); end
    end
    checks++; if (dsig_cyc.size() != 1) begin errors++; $display("FAIL stream_done_pulses got %0d want 1", dsig_cyc.size()); end
    if (dsig_cyc.size() > 0 && done_cyc.size() > 0) begin
      checks++; if (dsig_cyc[0] != done_cyc[$] + 1) begin errors++; $display("FAIL stream_done_cycle got %0d want %0d", dsig_cyc[0], done_cyc[$] + 1); end
    end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL stream_hold got %0d violations want 0", hold_viol); end
  endtask

  task automatic test_start_held();
    bit ok;
    clear_logs();
    repeat (100) @(negedge CLK);
    checks++; if (cap_q.size() != 0) begin errors++; $display("FAIL held_no_retrigger got %0d words want 0", cap_q.size()); end
    checks++; if (dsig_cyc.size() != 0) begin errors++; $display("FAIL held_no_done got %0d pulses want 0", dsig_cyc.size()); end
    checks++; if (LCD_RST_Out !== 1'b1) begin errors++; $display("FAIL held_lcd_rst got %b want 1", LCD_RST_Out); end
    Start_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    wr_lat = 0;
    Start_Sig = 1'b1;
    wait_for_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL held_restart_timeout got no Done_Sig want pulse"); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL held_restart_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL held_restart_word%0d got %h want %h", k, cap_q[k], exp_q[k]); end
    end
    checks++; if (dsig_cyc.size() != 1) begin errors++; $display("FAIL held_restart_done got %0d pulses want 1", dsig_cyc.size()); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL held_restart_hold got %0d violations want 0", hold_viol); end
  endtask

  task automatic test_start_drop();
    bit ok;
    bit seen_low = 1'b0;
    Start_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    clear_logs();
    wr_lat = 0;
    Start_Sig = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (seen_low && LCD_RST_Out === 1'b1) break;
      if (LCD_RST_Out === 1'b0) seen_low = 1'b1;
    end
    repeat (2) @(negedge CLK);
    Start_Sig = 1'b0;
    wait_for_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout got no Done_Sig want pulse"); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL drop_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL drop_word%0d got %h want %h", k, cap_q[k], exp_q[k]); end
    end
    checks++; if (dsig_cyc.size() != 1) begin errors++; $display("FAIL drop_done got %0d pulses want 1", dsig_cyc.size()); end
  endtask

  task automatic test_stray_done();
    bit ok;
    repeat (2) @(negedge CLK);
    clear_logs();
    wr_lat = 0;
    Start_Sig = 1'b1;
    stray_done = 1'b1;
    @(negedge CLK);
    stray_done = 1'b0;
    checks++; if (LCD_RST_Out !== 1'b0) begin errors++; $display("FAIL stray_start_taken got %b want 0", LCD_RST_Out); end
    stray_done = 1'b1;
    @(negedge CLK);
    stray_done = 1'b0;
    repeat (int'(L)) @(negedge CLK);
    stray_done = 1'b1;
    @(negedge CLK);
    stray_done = 1'b0;
    wait_for_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stray_timeout got no Done_Sig want pulse"); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL stray_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL stray_word%0d got %h want %h", k, cap_q[k], exp_q[k]); end
    end
    checks++; if (dsig_cyc.size() != 1) begin errors++; $display("FAIL stray_done got %0d pulses want 1", dsig_cyc.size()); end
    Start_Sig = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit reached = 1'b0;
    int idle_viol = 0;
    repeat (2) @(negedge CLK);
    clear_logs();
    wr_lat = 10;
    Start_Sig = 1'b1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge CLK);
      if (cap_q.size() >= 3) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("FAIL midrst_reach got %0d words want 3", cap_q.size()); end
    @(negedge CLK);
    RST = 1'b1;
    wr_flush = 1'b1;
    Start_Sig = 1'b0;
    @(negedge CLK);
    checks++; if (spi.SPI_Start_Sig !== 1'b0) begin errors++; $display("FAIL midrst_spi_start got %b want 0", spi.SPI_Start_Sig); end
    checks++; if (spi.SPI_Data !== 10'h000) begin errors++; $display("FAIL midrst_spi_data got %h want 000", spi.SPI_Data); end
    checks++; if (LCD_RST_Out !== 1'b1) begin errors++; $display("FAIL midrst_lcd_rst got %b want 1", LCD_RST_Out); end
    checks++; if (Done_Sig !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", Done_Sig); end
    @(negedge CLK);
    RST = 1'b0;
    wr_flush = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (LCD_RST_Out !== 1'b1 || spi.SPI_Start_Sig !== 1'b0 || Done_Sig !== 1'b0) idle_viol++;
    end
    checks++; if (idle_viol != 0) begin errors++; $display("FAIL midrst_idle got %0d active cycles want 0", idle_viol); end
    clear_logs();
    wr_lat = 0;
    Start_Sig = 1'b1;
    wait_for_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_restart_timeout got no Done_Sig want pulse"); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_restart_count got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_restart_word%0d got %h want %h", k, cap_q[k], exp_q[k]); end
    end
    checks++; if (dsig_cyc.size() != 1) begin errors++; $display("FAIL midrst_restart_done got %0d pulses want 1", dsig_cyc.size()); end
    Start_Sig = 1'b0;
  endtask

  initial begin
    build_expected();
    @(negedge CLK);
    test_reset();
    test_command_stream();
    test_start_held();
    test_start_drop();
    test_stray_done();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_init_module.md
# lcd_init_module

Power-up initialisation stage for the SPI 12864 LCD (ST7565-class controller), sitting directly upstream of the draw stage. On a start request it drives the panel hardware-reset pin through its low/recovery timing, then streams a fixed command list as 10-bit words into the shared SPI write module via the Start/Done handshake. It pulses Done_Sig so the top-level controller can hand the SPI writer to the draw stage.

## Interface
- RST_LOW_CYC, 50000: cycles LCD_RST_Out is held low (1 ms at 50 MHz).
- RST_WAIT_CYC, 250000: cycles after LCD_RST_Out rises before the first SPI word (5 ms).
- CONTRAST, 8'h20: electronic-volume byte sent after command 0x81.
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset; one clock, synchronous and active-high.
- Start_Sig  input  1  level request from the top controller.
- SPI_Done_Sig  input  1  one-cycle pulse from the SPI writer: word shifted out.
- SPI_Start_Sig  output  1  level request to the SPI writer.
- SPI_Data  output  10  [9] reserved, driven 0; [8] DC (0 = command, 1 = display data); [7:0] byte.
- LCD_RST_Out  output  1  panel hardware reset, active-low.
- Done_Sig  output  1  one-cycle pulse: sequence complete.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, ISSUE, WAIT_DONE, GAP, DONE, HOLD.
- IDLE: Start_Sig=1 -> RST_LOW, delay counter cleared.
- RST_LOW: LCD_RST_Out=0; after RST_LOW_CYC cycles -> RST_WAIT.
- RST_WAIT: LCD_RST_Out=1; after RST_WAIT_CYC cycles -> ISSUE with word index 0.
- Command list (DC=0, in order): E2, A2, A0, C8, 2F, 24, 81, CONTRAST, AF (9 words).
- ISSUE: load SPI_Data from the index, assert SPI_Start_Sig -> WAIT_DONE.
- WAIT_DONE: hold SPI_Start_Sig and SPI_Data. On SPI_Done_Sig, drop SPI_Start_Sig and advance the index. Go to GAP, or to DONE after the last word.
- GAP: exactly one cycle with SPI_Start_Sig=0 so the writer re-arms -> ISSUE.
- DONE: Done_Sig=1 for one cycle -> HOLD.
- HOLD: wait for Start_Sig=0 -> IDLE. A held-high Start_Sig never retriggers.
- Start_Sig falling mid-sequence is ignored; the sequence runs to DONE.
- SPI_Done_Sig outside WAIT_DONE is ignored.
- Delay counters are 18 bits minimum and must cover both parameter values. The index width must cover the longest list, including the clear option.

## Timing
- Reset values: SPI_Start_Sig=0, SPI_Data=10'h000, LCD_RST_Out=1, Done_Sig=0, state IDLE, counters and index 0.
- RST asserted in any state returns to these values on the next edge and aborts any word in flight.
- Start_Sig sampled high at edge N -> LCD_RST_Out=0 from N+1 through N+RST_LOW_CYC, high from N+RST_LOW_CYC+1.
- First SPI_Start_Sig rises RST_WAIT_CYC cycles after LCD_RST_Out rises.
- SPI_Done_Sig at edge M -> SPI_Start_Sig=0 at M+1 (GAP), next word's SPI_Start_Sig=1 at M+2.
- After the last SPI_Done_Sig at edge M, Done_Sig is high during cycle M+1 only.
- Start_Sig and SPI_Done_Sig high in the same cycle in IDLE: start is taken and the stray done is ignored.

## Configuration
- LCD_INIT_CLEAR_EN defined: after AF, the module clears display RAM. For each page p=0..7 it sends B0|p, 10, 00 (DC=0), then 128 words 00 (DC=1). That adds 1048 words, 1057 total. Done_Sig follows the final data word.
- Not defined: the sequence ends after AF (9 words) and the clear logic is not synthesised.

## Test plan
- RST held 2 cycles mid-WAIT_DONE -> all outputs at reset values next edge; state IDLE; restart works normally.
- RST_LOW_CYC=4, RST_WAIT_CYC=6, Start_Sig rise at edge 10 -> LCD_RST_Out low edges 11–14; first SPI_Start_Sig at edge 21.
- Writer model answering Done 3 cycles after start, macro off -> 9 words E2,A2,A0,C8,2F,24,81,20,AF with DC=0. Exactly one GAP cycle between words; one Done_Sig pulse.
- Start_Sig held high 100 cycles past Done_Sig -> no second sequence; drop then re-raise -> a full new sequence.
- Start_Sig dropped during RST_WAIT -> the sequence still completes all words and pulses Done_Sig.
- Macro on -> 1057 words. Word 9 is 0x0B0, words 12–139 are 0x100, and the last page header is B7,10,00.
